// File: rtl/ovi_lsu_mem_adapter_pkg.sv
// Shared types for the OVI load/store memory adapter: core-side bus structs,
// memory request struct, arbiter states and the misaligned-load poison word.
package ovi_lsu_mem_adapter_pkg;

  typedef struct packed {
    logic        load_valid;
    logic        store_valid;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
  } core_out_loadstore_bus;

  typedef struct packed {
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_ready;
  } core_in_loadstore_bus;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ovi_mem_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ_W = 2'd1,
    ARB_REQ_R = 2'd2
  } arb_state_e;

  localparam logic [31:0] OVI_MEM_POISON = 32'hDEAD_BEEF;

  function automatic logic addr_misaligned(input logic [31:0] a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/ovi_lsu_mem_adapter_fifo.sv
// Synchronous FIFO with async active-low reset; count carries the extra bit
// that separates full from empty. Push when full / pop when empty are ignored.
module ovi_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ovi_lsu_mem_adapter.sv
// Core-side OVI load/store memory stage: store FIFO + load queue feeding one
// in-order req/gnt/rvalid port, stores always drained before loads issue.
// Optional macro OVI_MEMADP_ALIGN_CHK_EN enables misaligned-address checking.
module ovi_lsu_mem_adapter
  import ovi_lsu_mem_adapter_pkg::*;
#(
  parameter int ST_DEPTH = 4,
  parameter int LD_DEPTH = 2,
  parameter int MAX_OUT  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  core_out_loadstore_bus CORE_OUT_LOADSTORE,
  output core_in_loadstore_bus  CORE_IN_LOADSTORE,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [31:0]           MEM_ADDR,
  output logic [31:0]           MEM_WDATA,
  input  logic                  MEM_GNT,
  input  logic                  MEM_RVALID,
  input  logic [31:0]           MEM_RDATA,
  output logic                  ERR_MISALIGN
);

  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int SCW = $clog2(ST_DEPTH + 1);
  localparam int LCW = $clog2(LD_DEPTH + 1);

  logic ld_in, st_in, poison_emit, rvalid_eff;

`ifdef OVI_MEMADP_ALIGN_CHK_EN
  logic mis, err_q, poison_q;
  assign mis   = addr_misaligned(CORE_OUT_LOADSTORE.mem_addr);
  assign ld_in = CORE_OUT_LOADSTORE.load_valid & ~mis;
  assign st_in = CORE_OUT_LOADSTORE.store_valid & ~mis;
  // A discarded load answers with poison next cycle; it only waits if a real RVALID collides.
  assign poison_emit  = (poison_q | (CORE_OUT_LOADSTORE.load_valid & mis)) & ~rvalid_eff;
  assign ERR_MISALIGN = err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q    <= 1'b0;
      poison_q <= 1'b0;
    end else begin
      if ((CORE_OUT_LOADSTORE.load_valid | CORE_OUT_LOADSTORE.store_valid) & mis) err_q <= 1'b1;
      poison_q <= (poison_q | (CORE_OUT_LOADSTORE.load_valid & mis)) & rvalid_eff;
    end
  end
`else
  assign ld_in        = CORE_OUT_LOADSTORE.load_valid;
  assign st_in        = CORE_OUT_LOADSTORE.store_valid;
  assign poison_emit  = 1'b0;
  assign ERR_MISALIGN = 1'b0;
`endif

  st_entry_t        st_head;
  logic             st_full, st_empty, st_pop;
  logic [SCW-1:0]   st_cnt;
  logic [31:0]      ld_head;
  logic             ld_full, ld_empty, ld_pop, ld_bypass;
  logic [LCW-1:0]   ld_cnt;

  ovi_sync_fifo #(.WIDTH($bits(st_entry_t)), .DEPTH(ST_DEPTH)) u_st_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (st_in),
    .din_i   ({CORE_OUT_LOADSTORE.mem_addr, CORE_OUT_LOADSTORE.store_data}),
    .pop_i   (st_pop),
    .dout_o  (st_head),
    .full_o  (st_full),
    .empty_o (st_empty),
    .count_o (st_cnt)
  );

  ovi_sync_fifo #(.WIDTH(32), .DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (ld_in & ~ld_bypass),
    .din_i   (CORE_OUT_LOADSTORE.mem_addr),
    .pop_i   (ld_pop),
    .dout_o  (ld_head),
    .full_o  (ld_full),
    .empty_o (ld_empty),
    .count_o (ld_cnt)
  );

  arb_state_e   state_q, state_d;
  ovi_mem_req_t req_q, req_d;
  logic         mem_req_q, mem_req_d;
  logic         byp_q, byp_d;
  logic [OW-1:0] out_q;
  logic         out_inc, out_ok, launch;
  logic         lv_q;
  logic [31:0]  ld_data_q;

  assign out_ok     = (out_q < OW'(MAX_OUT));
  assign rvalid_eff = MEM_RVALID & (out_q != '0);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    byp_d     = byp_q;
    st_pop    = 1'b0;
    ld_pop    = 1'b0;
    ld_bypass = 1'b0;
    out_inc   = 1'b0;
    launch    = 1'b0;
    case (state_q)
      ARB_IDLE:  launch = 1'b1;
      ARB_REQ_W: if (MEM_GNT) begin
        st_pop    = 1'b1;
        mem_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end
      ARB_REQ_R: if (MEM_GNT) begin
        ld_pop    = ~byp_q;
        out_inc   = 1'b1;
        mem_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end
      default:   state_d = ARB_IDLE;
    endcase
    // A store arriving this cycle also blocks loads, so no load can slip ahead of it.
    if (launch) begin
      if (!st_empty) begin
        mem_req_d   = 1'b1;
        req_d.we    = 1'b1;
        req_d.addr  = st_head.addr;
        req_d.wdata = st_head.data;
        state_d     = ARB_REQ_W;
      end else if (!st_in && out_ok && (!ld_empty || ld_in)) begin
        ld_bypass   = ld_empty;
        byp_d       = ld_empty;
        mem_req_d   = 1'b1;
        req_d.we    = 1'b0;
        req_d.addr  = ld_empty ? CORE_OUT_LOADSTORE.mem_addr : ld_head;
        req_d.wdata = '0;
        state_d     = ARB_REQ_R;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      byp_q     <= 1'b0;
      out_q     <= '0;
      lv_q      <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      byp_q     <= byp_d;
      out_q     <= out_q + OW'(out_inc) - OW'(rvalid_eff);
      lv_q      <= rvalid_eff | poison_emit;
      if (rvalid_eff)       ld_data_q <= MEM_RDATA;
      else if (poison_emit) ld_data_q <= OVI_MEM_POISON;
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = req_q.we;
  assign MEM_ADDR  = req_q.addr;
  assign MEM_WDATA = req_q.wdata;

  assign CORE_IN_LOADSTORE.load_valid  = lv_q;
  assign CORE_IN_LOADSTORE.load_data   = ld_data_q;
  // Two free slots: the bridge pushes one cycle after sampling ready.
  assign CORE_IN_LOADSTORE.store_ready = (int'(st_cnt) + 2) <= ST_DEPTH;

  ast_st_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(st_in && st_full));
  ast_ld_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(ld_in && ld_full));
  ast_ld_count:    assert property (@(posedge CLK) disable iff (!RST_N) int'(ld_cnt) <= LD_DEPTH);

endmodule

// File: tb/tb_ovi_lsu_mem_adapter.sv
// Bench for ovi_lsu_mem_adapter: memory model with programmable GNT stall and
// RVALID delay, write/load scoreboards and per-scenario tasks.
module tb_ovi_lsu_mem_adapter;
  import ovi_lsu_mem_adapter_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  core_out_loadstore_bus co = '0;
  core_in_loadstore_bus  ci;
  logic        MEM_REQ, MEM_WE, ERR_MISALIGN;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_GNT = 1'b0, MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;

  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  ovi_lsu_mem_adapter u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .CORE_OUT_LOADSTORE(co), .CORE_IN_LOADSTORE(ci),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .ERR_MISALIGN(ERR_MISALIGN)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; int due; } rd_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_ld[$];
  rd_t         rd_q[$];
  logic [31:0] mem_m   [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int cyc = 0, gnt_stall = 0, rv_delay = 1;
  int n_wr_gnt = 0, n_rd_gnt = 0, n_rv = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory model: drives GNT/RVALID at negedge; a grant logged here is accepted at the next posedge.
  always @(negedge CLK) begin
    wr_t w;
    rd_t r;
    MEM_RVALID = 1'b0;
    if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = rd_q[0].data;
      rd_q.delete(0);
      n_rv++;
    end
    MEM_GNT = 1'b0;
    if (gnt_stall > 0) gnt_stall--;
    else if (MEM_REQ === 1'b1 && RST_N) begin
      MEM_GNT = 1'b1;
      if (MEM_WE) begin
        mem_m[MEM_ADDR] = MEM_WDATA;
        n_wr_gnt++;
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got addr=%h data=%h want no write", MEM_ADDR, MEM_WDATA);
        end else begin
          w = exp_wr.pop_front();
          if (MEM_ADDR !== w.addr || MEM_WDATA !== w.data) begin
            failures++;
            $display("FAIL wr_order got addr=%h data=%h want addr=%h data=%h", MEM_ADDR, MEM_WDATA, w.addr, w.data);
          end
        end
      end else begin
        r.data = mem_m.exists(MEM_ADDR) ? mem_m[MEM_ADDR] : dflt(MEM_ADDR);
        r.due  = cyc + rv_delay;
        rd_q.push_back(r);
        n_rd_gnt++;
      end
    end
    cyc++;
  end

  // Load-response scoreboard.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (RST_N && ci.load_valid === 1'b1) begin
      checks++;
      if (exp_ld.size() == 0) begin
        failures++;
        $display("FAIL ld_unexpected got data=%h want no load_valid", ci.load_data);
      end else begin
        e = exp_ld.pop_front();
        if (ci.load_data !== e) begin
          failures++;
          $display("FAIL ld_data got %h want %h", ci.load_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic put_load(input logic [31:0] a, input logic [31:0] e);
    co.load_valid = 1'b1;
    co.mem_addr   = a;
    exp_ld.push_back(e);
    tick();
    co.load_valid = 1'b0;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    co.store_valid = 1'b1;
    co.mem_addr    = a;
    co.store_data  = d;
    exp_wr.push_back(w);
    ref_mem[a] = d;
    tick();
    co.store_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    checks++;
    if (MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h want all 0", MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    checks++;
    if (ci.load_valid !== 1'b0 || ci.load_data !== 32'h0 || ERR_MISALIGN !== 1'b0) begin
      failures++;
      $display("FAIL reset_core got lv=%b ld=%h err=%b want 0", ci.load_valid, ci.load_data, ERR_MISALIGN);
    end
    checks++;
    if (ci.store_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", ci.store_ready);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    mem_m[32'h100]   = 32'h1234_5678;
    ref_mem[32'h100] = 32'h1234_5678;
    put_load(32'h100, 32'h1234_5678);
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h100) begin
      failures++;
      $display("FAIL single_req got req=%b we=%b addr=%h want 1 0 00000100", MEM_REQ, MEM_WE, MEM_ADDR);
    end
    tick();
    checks++;
    if (ci.load_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got lv=%b want 0", ci.load_valid);
    end
    tick();
    checks++;
    if (ci.load_valid !== 1'b1 || ci.load_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL single_lat3 got lv=%b data=%h want 1 12345678", ci.load_valid, ci.load_data);
    end
    tick();
    checks++;
    if (ci.load_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse got lv=%b want 0", ci.load_valid);
    end
  endtask

  task automatic test_store_burst();
    int sent = 0, guard = 0, base = n_wr_gnt;
    logic prev_rdy = 1'b1, cur, want;
    bit saw_low = 0;
    gnt_stall = 10;
    while (sent < 16 && guard < 300) begin
      cur = ci.store_ready;
      if (cur === 1'b0) saw_low = 1;
      if (n_wr_gnt == base) begin
        want = (4 - sent) >= 2;
        checks++;
        if (cur !== want) begin
          failures++;
          $display("FAIL burst_ready count=%0d got %b want %b", sent, cur, want);
        end
      end
      if (prev_rdy) begin
        put_store(32'h200 + 32'(4 * sent), $urandom);
        sent++;
      end else tick();
      prev_rdy = cur;
      guard++;
    end
    guard = 0;
    while (n_wr_gnt - base < 16 && guard < 200) begin tick(); guard++; end
    checks++;
    if (sent != 16 || n_wr_gnt - base != 16 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL burst_count got sent=%0d writes=%0d left=%0d want 16 16 0", sent, n_wr_gnt - base, exp_wr.size());
    end
    checks++;
    if (!saw_low) begin
      failures++;
      $display("FAIL burst_backpressure got ready never low want low during stall");
    end
    tick(); tick();
  endtask

  task automatic test_ordering();
    int base_w = n_wr_gnt, guard = 0, wr_at_read = -1;
    gnt_stall = 3;
    put_store(32'h200, 32'hAAAA_0001);
    put_store(32'h204, 32'hAAAA_0002);
    put_store(32'h200, 32'hAAAA_0003);
    put_load(32'h200, ref_rd(32'h200));
    while ((exp_ld.size() != 0 || wr_at_read < 0) && guard < 100) begin
      if (wr_at_read < 0 && MEM_REQ === 1'b1 && MEM_WE === 1'b0) wr_at_read = n_wr_gnt - base_w;
      tick();
      guard++;
    end
    checks++;
    if (wr_at_read != 3) begin
      failures++;
      $display("FAIL order_read_after_writes got %0d writes done want 3", wr_at_read);
    end
    checks++;
    if (exp_ld.size() != 0) begin
      failures++;
      $display("FAIL order_timeout got %0d loads pending want 0", exp_ld.size());
    end
  endtask

  task automatic test_outstanding();
    int base_r = n_rd_gnt, base_v = n_rv, guard = 0, o, max_o = 0, rv_at_third = -1;
    rv_delay = 6;
    put_load(32'h300, ref_rd(32'h300));
    put_load(32'h304, ref_rd(32'h304));
    put_load(32'h308, ref_rd(32'h308));
    while (exp_ld.size() != 0 && guard < 150) begin
      o = (n_rd_gnt - base_r) - (n_rv - base_v);
      if (o > max_o) max_o = o;
      if (rv_at_third < 0 && n_rd_gnt - base_r >= 3) rv_at_third = n_rv - base_v;
      tick();
      guard++;
    end
    checks++;
    if (max_o != 2) begin
      failures++;
      $display("FAIL outst_max got %0d want 2", max_o);
    end
    checks++;
    if (rv_at_third < 1) begin
      failures++;
      $display("FAIL outst_third got rvalids_before=%0d want >=1", rv_at_third);
    end
    checks++;
    if (exp_ld.size() != 0) begin
      failures++;
      $display("FAIL outst_timeout got %0d loads pending want 0", exp_ld.size());
    end
    rv_delay = 1;
  endtask

  task automatic test_reset_midop();
    int base_r = n_rd_gnt, guard = 0, req_seen = 0, lv_seen = 0;
    rv_delay = 30;
    put_load(32'h400, ref_rd(32'h400));
    while (n_rd_gnt == base_r && guard < 20) begin tick(); guard++; end
    tick();
    gnt_stall = 100;
    put_store(32'h500, 32'h5555_0000);
    put_store(32'h504, 32'h5555_0004);
    tick();
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0 ||
        ci.load_valid !== 1'b0 || ERR_MISALIGN !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got req=%b we=%b addr=%h wdata=%h lv=%b err=%b want all 0",
               MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, ci.load_valid, ERR_MISALIGN);
    end
    exp_wr.delete();
    exp_ld.delete();
    ref_mem.delete(32'h500);
    ref_mem.delete(32'h504);
    tick(); tick();
    RST_N = 1'b1;
    gnt_stall = 0;
    for (int i = 0; i < 40; i++) begin
      if (MEM_REQ !== 1'b0) req_seen++;
      if (ci.load_valid !== 1'b0) lv_seen++;
      tick();
    end
    checks++;
    if (req_seen != 0 || lv_seen != 0) begin
      failures++;
      $display("FAIL rst_drop got req_cycles=%0d lv_cycles=%0d want 0 0", req_seen, lv_seen);
    end
    rv_delay = 1;
  endtask

  task automatic test_misalign();
`ifdef OVI_MEMADP_ALIGN_CHK_EN
    int base_r = n_rd_gnt, base_w = n_wr_gnt, req_seen = 0;
    put_load(32'h102, OVI_MEM_POISON);
    checks++;
    if (ci.load_valid !== 1'b1 || ci.load_data !== 32'hDEAD_BEEF || ERR_MISALIGN !== 1'b1) begin
      failures++;
      $display("FAIL mis_poison got lv=%b data=%h err=%b want 1 deadbeef 1", ci.load_valid, ci.load_data, ERR_MISALIGN);
    end
    co.store_valid = 1'b1;
    co.mem_addr    = 32'h201;
    co.store_data  = 32'h7777_7777;
    tick();
    co.store_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (MEM_REQ !== 1'b0) req_seen++;
      tick();
    end
    checks++;
    if (req_seen != 0 || n_rd_gnt != base_r || n_wr_gnt != base_w || ERR_MISALIGN !== 1'b1) begin
      failures++;
      $display("FAIL mis_discard got req_cycles=%0d err=%b want 0 1", req_seen, ERR_MISALIGN);
    end
`else
    int guard = 0;
    put_load(32'h102, ref_rd(32'h102));
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h102) begin
      failures++;
      $display("FAIL mis_forward got req=%b we=%b addr=%h want 1 0 00000102", MEM_REQ, MEM_WE, MEM_ADDR);
    end
    while (exp_ld.size() != 0 && guard < 20) begin tick(); guard++; end
    checks++;
    if (exp_ld.size() != 0 || ERR_MISALIGN !== 1'b0) begin
      failures++;
      $display("FAIL mis_noflag got pending=%0d err=%b want 0 0", exp_ld.size(), ERR_MISALIGN);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_burst();
    test_ordering();
    test_outstanding();
    test_reset_midop();
    test_misalign();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
